// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a 4-bit universal shift register: one op per handshake, then a done pulse.
// Optional abort input and sticky aborted flag are built when SHIFT_SEQ_ABORT_EN is defined.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] reg_q,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [1:0]       sel,
  output logic             sinl,
  output logic             sinr,
  output logic [WIDTH-1:0] par_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       op_reg;
  logic             sinl_reg;
  logic             abort_hit;
  logic             op_end;
  logic             unused_reg_q;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Only the MSB feeds back (rotate); the lower bits are not needed here.
  assign unused_reg_q = ^reg_q[WIDTH-2:0];

  assign cmd_ready = (state_reg == IDLE);
  assign op_end    = (state_reg == LOAD) || (cnt_reg == CNT_W'(1)) || abort_hit;

  // Rotate feeds the live MSB straight back so every shift edge sees the current value.
  assign sinl = (state_reg == SHIFT && op_reg == OP_ROTL) ? reg_q[WIDTH-1] : sinl_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_LOAD;
      sel       <= SEL_HOLD;
      sinl_reg  <= 1'b0;
      sinr      <= 1'b0;
      par_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            op_reg <= cmd_op;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            if (cmd_op == OP_LOAD) begin
              state_reg <= LOAD;
              sel       <= SEL_LOAD;
              par_out   <= cmd_data;
              busy      <= 1'b1;
            end else if (cmd_count == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= SHIFT;
              cnt_reg   <= cmd_count;
              sel       <= (cmd_op == OP_SHR) ? SEL_SHR : SEL_SHL;
              sinl_reg  <= (cmd_op == OP_SHL) & cmd_fill;
              sinr      <= (cmd_op == OP_SHR) & cmd_fill;
              busy      <= 1'b1;
            end
          end
        end
        LOAD, SHIFT: begin
          if (op_end) begin
            state_reg <= DONE;
            cnt_reg   <= '0;
            sel       <= SEL_HOLD;
            sinl_reg  <= 1'b0;
            sinr      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted   <= abort;
`endif
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Table-driven bench for shift_seq_ctrl with a behavioural 4-bit shift register on reg_q.
module tb_shift_seq_ctrl;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic [3:0] cmd_data;
  logic       cmd_fill;
  logic [3:0] reg_q = 4'b0000;
  logic [1:0] sel;
  logic       sinl;
  logic       sinr;
  logic [3:0] par_out;
  logic       busy;
  logic       done;
`ifdef SHIFT_SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] op;
    logic [2:0] cnt;
    logic [3:0] data;
    logic       fill;
    logic [3:0] exp_q;
    int         exp_lat;
    int         exp_act;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[10];

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .cmd_fill  (cmd_fill),
    .reg_q     (reg_q),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .sel       (sel),
    .sinl      (sinl),
    .sinr      (sinr),
    .par_out   (par_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Universal shift register driven by the controller; not reset by rst.
  always_ff @(posedge clk) begin
    case (sel)
      2'b00:   reg_q <= par_out;
      2'b01:   reg_q <= {reg_q[2:0], sinl};
      2'b10:   reg_q <= {sinr, reg_q[3:1]};
      default: reg_q <= reg_q;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    int k;
    int lat;
    int act;
    int selbad;
    @(negedge clk);
    chk("ready_pre", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_count = v.cnt;
    cmd_data  = v.data;
    cmd_fill  = v.fill;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1; lat = 0; act = 0; selbad = 0;
    while (lat == 0 && k <= 20) begin
      if (sel != 2'b11) begin
        act++;
        if (sel != v.exp_sel) selbad++;
      end
      if (done) lat = k;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk("latency", lat, v.exp_lat);
    chk("active_cycles", act, v.exp_act);
    chk("sel_code_bad", selbad, 0);
    chk("reg_q", reg_q, v.exp_q);
    @(negedge clk);
    chk("done_one_pulse", done, 0);
    chk("ready_post", cmd_ready, 1);
    chk("busy_post", busy, 0);
    $display("txn %0d op=%0d cnt=%0d data=%b fill=%0d -> q=%b lat=%0d act=%0d",
             idx, v.op, v.cnt, v.data, v.fill, reg_q, lat, act);
  endtask

  initial begin
    int ready_hi;
    vecs[0] = '{OP_LOAD, 3'd0, 4'b1011, 1'b0, 4'b1011, 2, 1, 2'b00};
    vecs[1] = '{OP_SHL,  3'd2, 4'b0000, 1'b0, 4'b1100, 3, 2, 2'b01};
    vecs[2] = '{OP_SHR,  3'd3, 4'b0000, 1'b1, 4'b1111, 4, 3, 2'b10};
    vecs[3] = '{OP_LOAD, 3'd0, 4'b1000, 1'b0, 4'b1000, 2, 1, 2'b00};
    vecs[4] = '{OP_ROTL, 3'd5, 4'b0000, 1'b0, 4'b0001, 6, 5, 2'b01};
    vecs[5] = '{OP_ROTL, 3'd0, 4'b0000, 1'b0, 4'b0001, 1, 0, 2'b11};
    vecs[6] = '{OP_SHR,  3'd1, 4'b0000, 1'b0, 4'b0000, 2, 1, 2'b10};
    vecs[7] = '{OP_LOAD, 3'd0, 4'b0110, 1'b0, 4'b0110, 2, 1, 2'b00};
    vecs[8] = '{OP_SHL,  3'd7, 4'b0000, 1'b1, 4'b1111, 8, 7, 2'b01};
    vecs[9] = '{OP_SHR,  3'd0, 4'b0000, 1'b0, 4'b1111, 1, 0, 2'b11};

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 3'd0;
    cmd_data = 4'b0000; cmd_fill = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 2'b11);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_par_out", par_out, 0);
    chk("rst_sinl", sinl, 0);
    chk("rst_sinr", sinr, 0);
    chk("rst_ready", cmd_ready, 1);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_cmd(vecs[i], i);
    chk("par_out_holds_last_load", par_out, 4'b0110);

    // cmd_valid held high across a 7-shift SHL: single accept, next only after done.
    @(negedge clk);
    chk("cont_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_SHL; cmd_count = 3'd7; cmd_fill = 1'b1;
    ready_hi = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cmd_ready) ready_hi++;
      if (k == 1) chk("cont_busy", busy, 1);
      if (k == 8) begin
        chk("cont_done_at_8", done, 1);
        cmd_fill = 1'b0;
      end
    end
    chk("cont_ready_while_busy", ready_hi, 0);
    @(negedge clk);
    chk("cont_ready_after_done", cmd_ready, 1);
    chk("cont_done_cleared", done, 0);
    @(negedge clk);
    chk("cont_second_accept_busy", busy, 1);
    chk("cont_second_ready_low", cmd_ready, 0);
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_sel", sel, 2'b11);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    ready_hi = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) ready_hi++;
    end
    chk("midrst_no_done", ready_hi, 0);
    chk("midrst_partial_q", reg_q, 4'b1100);
    $display("txn mid-reset SHL q=%b", reg_q);

`ifdef SHIFT_SEQ_ABORT_EN
    run_cmd('{OP_LOAD, 3'd0, 4'b1010, 1'b0, 4'b1010, 2, 1, 2'b00}, 10);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_no_done", done, 0);
    chk("idle_abort_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_SHR; cmd_count = 3'd6; cmd_fill = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_sel", sel, 2'b11);
    chk("abort_done", done, 1);
    chk("abort_flag", aborted, 1);
    chk("abort_busy", busy, 0);
    chk("abort_q_two_shifts", reg_q, 4'b1110);
    @(negedge clk);
    chk("abort_sticky", aborted, 1);
    chk("abort_done_pulse", done, 0);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 4'b0011;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_cleared_on_accept", aborted, 0);
    chk("abort_next_load_sel", sel, 2'b00);
    $display("txn abort SHR q=%b", reg_q);
    repeat (3) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
